ram_access_master: RTL and testbench
====================================

Name: ram_access_master

Overview:
Initiator-side controller that drives the ram_4096 port set (clk, data_in, data_out, wr_address, rd_address, read, write) from a burst command interface. It accepts single or burst read/write commands over valid/ready and generates wrapping addresses. Write beats stream in; read data returns through a credit-protected response FIFO with full backpressure. It sits between a bus-side agent and the ram_4096 instance.

Parameters:
DATA_W, 64, RAM data width
ADDR_W, 12, RAM address width (4096 words)
RD_LATENCY, 1, cycles from read being sampled high by the RAM to valid data_out (1..3)
RSP_DEPTH, 4, response FIFO depth, power of 2, must be >= RD_LATENCY+1

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDR_W  start address
cmd_len  in  4  beats minus one (1..16 beats)
wdata_valid  in  1  write beat valid
wdata_ready  out  1  write beat accepted
wdata  in  DATA_W  write beat data
rdata_valid  out  1  read response valid
rdata_ready  in  1  read response accepted
rdata  out  DATA_W  read response data
rdata_last  out  1  final beat of a read burst
busy  out  1  state!=IDLE, or reads in flight, or FIFO non-empty
ram_data_in  out  DATA_W  to RAM data_in
ram_data_out  in  DATA_W  from RAM data_out
ram_wr_address  out  ADDR_W  to RAM wr_address
ram_rd_address  out  ADDR_W  to RAM rd_address
ram_write  out  1  to RAM write
ram_read  out  1  to RAM read

Behaviour:
- Reset (resetn low, async): state IDLE; all outputs 0, including cmd_ready, wdata_ready, rdata_valid, rdata_last, busy, and all ram_* outputs. FIFO, in-flight pipeline and counters are cleared. cmd_ready goes high the first clk edge after reset deasserts.
- Reset mid-burst: the burst is aborted with no further RAM strobes. In-flight and queued read data is discarded.
- FSM states: IDLE, WRITE, READ.
  - IDLE: cmd_ready=1. On handshake, latch cmd_addr into addr_cnt and cmd_len into beat_cnt, then go to WRITE if cmd_write=1, else READ.
  - WRITE: cmd_ready=0, wdata_ready=1. Per wdata handshake, the next cycle drives ram_write=1, ram_wr_address=addr_cnt and ram_data_in=wdata (all registered, one-cycle latency). addr_cnt increments and beat_cnt decrements. After the last beat, go to IDLE.
  - READ: cmd_ready=0. A read issues in a cycle when credits = RSP_DEPTH - fifo_count - inflight > 0. Issuing means the next cycle has ram_read=1 and ram_rd_address=addr_cnt (registered). After the last issue, go to IDLE. Responses may still drain while IDLE accepts a new command.
- Address wrap: addr_cnt increments modulo 2^ADDR_W (4095 -> 0). There is no error.
- RAM strobes are single-cycle. ram_read and ram_write are never both asserted.
- Read capture: a valid/last shift pipeline of length RD_LATENCY tracks each ram_read. ram_data_out is pushed into the FIFO exactly RD_LATENCY cycles after the cycle ram_read=1, with last=1 on the final beat of the burst.
- The FIFO never overflows: credits count in-flight reads. Pushes never stall.
- Read port is a standard valid/ready FIFO head. rdata and rdata_last hold stable while valid&!ready. Simultaneous push and pop keeps the count unchanged. The FIFO may be full only with credits=0.
- Ordering: a write followed by a read to the same address returns the new data, because the write strobe precedes the read strobe by at least one cycle.
- Single-beat commands (cmd_len=0) return to IDLE after one beat.
- cmd_* inputs are ignored outside IDLE.

Test Plan:
- Reset mid-READ burst: cmd read addr 0x010 len 15, assert resetn low after 3 issues -> all outputs 0 immediately. After release, rdata_valid stays 0 and busy=0.
- Single write then read: write addr 0x123 data 64'hDEADBEEF_CAFEF00D, then read addr 0x123 len 0 -> one rdata beat equal to that value with rdata_last=1. Exactly one ram_write pulse and one ram_read pulse.
- Burst wrap: write 4 beats at 0xFFE with data 1,2,3,4 -> ram_wr_address sequence FFE, FFF, 000, 001. A read of 4 beats at 0xFFE returns 1,2,3,4 with last on beat 4.
- Backpressure: read 16 beats at 0x000 with rdata_ready=0 -> exactly RSP_DEPTH=4 ram_read pulses, then none. Release rdata_ready -> all 16 beats in order, no loss or duplicates.
- Write stalls: 3-beat write with wdata_valid gapped (1,0,0,1,1) -> exactly 3 ram_write pulses, each one cycle after its handshake. cmd_ready=0 until the last beat.
- RD_LATENCY=3 build: back-to-back 8-beat read with rdata_ready=1 -> first rdata_valid 4 cycles after the first ram_read cycle, and sustained 1 beat/cycle.

Source files
------------

// File: rtl/ram_access_master.sv
// Burst command master for a ram_4096-style port: single or burst reads and writes
// with wrapping addresses, and read data returned through a credit-protected FIFO.
module ram_access_master #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 12,
  parameter int RD_LATENCY = 1,
  parameter int RSP_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [3:0]        cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_last,
  output logic              busy,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic [ADDR_W-1:0] ram_wr_address,
  output logic [ADDR_W-1:0] ram_rd_address,
  output logic              ram_write,
  output logic              ram_read
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2} state_t;

  state_t              state_r, state_nxt_s;
  logic                cmd_ready_r, wdata_ready_r;
  logic [ADDR_W-1:0]   addr_cnt_r;
  logic [3:0]          beat_cnt_r;
  logic                ram_write_r, ram_read_r, ram_read_last_r;
  logic [ADDR_W-1:0]   ram_wr_address_r, ram_rd_address_r;
  logic [DATA_W-1:0]   ram_data_in_r;
  logic [RD_LATENCY-1:0] vld_pipe_r, last_pipe_r;
  logic [CW-1:0]       inflight_r, fifo_count_r, credits_s;
  logic [PW-1:0]       wr_ptr_r, rd_ptr_r;
  logic [DATA_W-1:0]   fifo_data_r [RSP_DEPTH];
  logic [RSP_DEPTH-1:0] fifo_last_r;
  logic                cmd_hs_s, wbeat_s, issue_s, last_beat_s, push_s, pop_s;

  assign cmd_hs_s    = cmd_valid & cmd_ready_r;
  assign last_beat_s = (beat_cnt_r == 4'd0);
  assign push_s      = vld_pipe_r[RD_LATENCY-1];
  assign pop_s       = (fifo_count_r != {CW{1'b0}}) & rdata_ready;
  // Every slot already holding data or promised to an in-flight read is unavailable.
  assign credits_s   = CW'(RSP_DEPTH) - fifo_count_r - inflight_r;

  // Next-state decode and per-cycle beat/issue decisions.
  always_comb begin
    state_nxt_s = state_r;
    wbeat_s     = 1'b0;
    issue_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_hs_s) state_nxt_s = cmd_write ? WRITE : READ;
        else          state_nxt_s = IDLE;
      end
      WRITE: begin
        wbeat_s = wdata_valid & wdata_ready_r;
        if (wbeat_s & last_beat_s) state_nxt_s = IDLE;
        else                       state_nxt_s = WRITE;
      end
      READ: begin
        issue_s = (credits_s != {CW{1'b0}});
        if (issue_s & last_beat_s) state_nxt_s = IDLE;
        else                       state_nxt_s = READ;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register, handshake readies and burst address/beat counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r       <= IDLE;
      cmd_ready_r   <= 1'b0;
      wdata_ready_r <= 1'b0;
      addr_cnt_r    <= {ADDR_W{1'b0}};
      beat_cnt_r    <= 4'd0;
    end else begin
      state_r       <= state_nxt_s;
      cmd_ready_r   <= (state_nxt_s == IDLE);
      wdata_ready_r <= (state_nxt_s == WRITE);
      if (cmd_hs_s) begin
        addr_cnt_r <= cmd_addr;
        beat_cnt_r <= cmd_len;
      end else if (wbeat_s | issue_s) begin
        addr_cnt_r <= addr_cnt_r + ADDR_W'(1);
        beat_cnt_r <= beat_cnt_r - 4'd1;
      end
    end
  end

  // Registered single-cycle RAM strobes with their address and data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ram_write_r      <= 1'b0;
      ram_read_r       <= 1'b0;
      ram_read_last_r  <= 1'b0;
      ram_wr_address_r <= {ADDR_W{1'b0}};
      ram_rd_address_r <= {ADDR_W{1'b0}};
      ram_data_in_r    <= {DATA_W{1'b0}};
    end else begin
      ram_write_r     <= wbeat_s;
      ram_read_r      <= issue_s;
      ram_read_last_r <= issue_s & last_beat_s;
      if (wbeat_s) begin
        ram_wr_address_r <= addr_cnt_r;
        ram_data_in_r    <= wdata;
      end
      if (issue_s) ram_rd_address_r <= addr_cnt_r;
    end
  end

  // Read-latency tracking pipeline and in-flight read count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe_r  <= {RD_LATENCY{1'b0}};
      last_pipe_r <= {RD_LATENCY{1'b0}};
      inflight_r  <= {CW{1'b0}};
    end else begin
      vld_pipe_r[0]  <= ram_read_r;
      last_pipe_r[0] <= ram_read_last_r;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe_r[i]  <= vld_pipe_r[i-1];
        last_pipe_r[i] <= last_pipe_r[i-1];
      end
      inflight_r <= inflight_r + CW'(issue_s) - CW'(push_s);
    end
  end

  // Response FIFO; pushes never stall because issue is gated by credits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < RSP_DEPTH; i++) fifo_data_r[i] <= {DATA_W{1'b0}};
      fifo_last_r  <= {RSP_DEPTH{1'b0}};
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      fifo_count_r <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= ram_data_out;
        fifo_last_r[wr_ptr_r] <= last_pipe_r[RD_LATENCY-1];
        wr_ptr_r              <= wr_ptr_r + PW'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PW'(1);
      fifo_count_r <= fifo_count_r + CW'(push_s) - CW'(pop_s);
    end
  end

  assign cmd_ready      = cmd_ready_r;
  assign wdata_ready    = wdata_ready_r;
  assign rdata_valid    = (fifo_count_r != {CW{1'b0}});
  assign rdata          = fifo_data_r[rd_ptr_r];
  assign rdata_last     = rdata_valid & fifo_last_r[rd_ptr_r];
  assign busy           = (state_r != IDLE) | (inflight_r != {CW{1'b0}}) | rdata_valid;
  assign ram_data_in    = ram_data_in_r;
  assign ram_wr_address = ram_wr_address_r;
  assign ram_rd_address = ram_rd_address_r;
  assign ram_write      = ram_write_r;
  assign ram_read       = ram_read_r;

endmodule

// File: tb/tb_ram_access_master.sv
// Directed bench for ram_access_master: a latency-1 instance on a RAM model plus a
// latency-3 instance on an address-pattern RAM.
module tb_ram_access_master;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic        wdata_valid, wdata_ready;
  logic [63:0] wdata;
  logic        rdata_valid, rdata_ready, rdata_last, busy;
  logic [63:0] rdata, ram_data_in, ram_data_out;
  logic [11:0] ram_wr_address, ram_rd_address;
  logic        ram_write, ram_read;

  logic        cmd_valid3, cmd_ready3, cmd_write3;
  logic [11:0] cmd_addr3;
  logic [3:0]  cmd_len3;
  logic        wdata_valid3, wdata_ready3;
  logic [63:0] wdata3;
  logic        rdata_valid3, rdata_ready3, rdata_last3, busy3;
  logic [63:0] rdata3, ram_data_in3, ram_data_out3;
  logic [11:0] ram_wr_address3, ram_rd_address3;
  logic        ram_write3, ram_read3;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0, wr3_cnt = 0;
  int rr_first = -1, rv_first = -1;
  logic [11:0] wr_log[$];
  logic [64:0] rx_log[$];
  logic [64:0] rx3_log[$];
  int          rx3_cyc[$];

  logic [63:0] ram_mem [4096];
  logic [63:0] r3_s0, r3_s1, r3_s2;

  ram_access_master #(.DATA_W(64), .ADDR_W(12), .RD_LATENCY(1), .RSP_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .rdata_last(rdata_last), .busy(busy),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
    .ram_wr_address(ram_wr_address), .ram_rd_address(ram_rd_address),
    .ram_write(ram_write), .ram_read(ram_read)
  );

  // Latency-3 build; the deeper FIFO lets credit return keep up with one beat per cycle.
  ram_access_master #(.DATA_W(64), .ADDR_W(12), .RD_LATENCY(3), .RSP_DEPTH(8)) dut3 (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_write(cmd_write3),
    .cmd_addr(cmd_addr3), .cmd_len(cmd_len3),
    .wdata_valid(wdata_valid3), .wdata_ready(wdata_ready3), .wdata(wdata3),
    .rdata_valid(rdata_valid3), .rdata_ready(rdata_ready3), .rdata(rdata3),
    .rdata_last(rdata_last3), .busy(busy3),
    .ram_data_in(ram_data_in3), .ram_data_out(ram_data_out3),
    .ram_wr_address(ram_wr_address3), .ram_rd_address(ram_rd_address3),
    .ram_write(ram_write3), .ram_read(ram_read3)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency stamps.
  always @(posedge clk) cyc <= cyc + 1;

  // Latency-1 RAM model.
  always @(posedge clk) begin
    if (ram_write) ram_mem[ram_wr_address] <= ram_data_in;
    if (ram_read)  ram_data_out <= ram_mem[ram_rd_address];
  end

  // Latency-3 RAM returning a pattern derived from the address.
  always @(posedge clk) begin
    r3_s0 <= 64'hA5A5_0000_0000_0000 | {52'h0, ram_rd_address3};
    r3_s1 <= r3_s0;
    r3_s2 <= r3_s1;
  end
  assign ram_data_out3 = r3_s2;

  // Monitors on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (ram_write) begin
      wr_cnt++;
      wr_log.push_back(ram_wr_address);
    end
    if (ram_read) rd_cnt++;
    if (ram_write && ram_read) both_cnt++;
    if (rdata_valid && rdata_ready) rx_log.push_back({rdata_last, rdata});
    if (ram_write3) wr3_cnt++;
    if (ram_read3 && rr_first < 0) rr_first = cyc;
    if (rdata_valid3 && rdata_ready3) begin
      if (rv_first < 0) rv_first = cyc;
      rx3_log.push_back({rdata_last3, rdata3});
      rx3_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [11:0] addr, input logic [3:0] len);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    for (int k = 0; k < 50 && !cmd_ready; k++) step();
    chk("cmd_ready_wait", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wbeat(input logic [63:0] d);
    wdata_valid = 1'b1; wdata = d;
    for (int k = 0; k < 50 && !wdata_ready; k++) step();
    chk("wdata_ready_wait", wdata_ready, 1);
    step();
    wdata_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int k = 0; k < budget && rx_log.size() < n; k++) step();
    chk("rx_count", rx_log.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb, rb, rdb, wrb, snap;
    logic [64:0] e;
    resetn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 12'h0; cmd_len = 4'h0;
    wdata_valid = 1'b0; wdata = 64'h0; rdata_ready = 1'b1;
    cmd_valid3 = 1'b0; cmd_write3 = 1'b0; cmd_addr3 = 12'h0; cmd_len3 = 4'h0;
    wdata_valid3 = 1'b0; wdata3 = 64'h0; rdata_ready3 = 1'b1;

    // Reset values
    step(); step();
    chk("reset_outputs", {cmd_ready, wdata_ready, rdata_valid, rdata_last, busy, ram_write, ram_read,
                          ram_wr_address, ram_rd_address, ram_data_in, rdata}, 0);
    resetn = 1'b1;
    chk("cmd_ready_before_edge", cmd_ready, 0);
    step();
    chk("cmd_ready_after_reset", cmd_ready, 1);
    chk("busy_idle", busy, 0);

    // Single write then single read of the same address
    wrb = wr_cnt; rdb = rd_cnt; rb = rx_log.size();
    send_cmd(1'b1, 12'h123, 4'd0);
    wbeat(64'hDEADBEEF_CAFEF00D);
    chk("single_wr_addr", ram_wr_address, 12'h123);
    send_cmd(1'b0, 12'h123, 4'd0);
    wait_rx(rb + 1, 20);
    step(); step(); step();
    chk("single_rd", rx_log[rb], {1'b1, 64'hDEADBEEF_CAFEF00D});
    chk("single_wr_pulses", wr_cnt - wrb, 1);
    chk("single_rd_pulses", rd_cnt - rdb, 1);

    // Gapped 3-beat write: each strobe one cycle after its handshake
    wrb = wr_cnt;
    send_cmd(1'b1, 12'h200, 4'd2);
    begin
      logic p [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      int beat = 0;
      for (int i = 0; i < 5; i++) begin
        wdata_valid = p[i]; wdata = 64'd100 + 64'(i);
        chk("stall_cmd_ready_low", cmd_ready, 0);
        step();
        chk("stall_wr_strobe", ram_write, p[i]);
        if (p[i]) begin
          chk("stall_wr_addr", ram_wr_address, 12'h200 + 12'(beat));
          chk("stall_wr_data", ram_data_in, 64'd100 + 64'(i));
          beat++;
        end
      end
    end
    wdata_valid = 1'b0;
    chk("stall_cmd_ready_back", cmd_ready, 1);
    step();
    chk("stall_wr_pulses", wr_cnt - wrb, 3);

    // Backpressure: 16-beat read held off by rdata_ready
    send_cmd(1'b1, 12'h000, 4'd15);
    for (int i = 0; i < 16; i++) wbeat(64'hB000 + 64'(i));
    step();
    rdata_ready = 1'b0;
    rdb = rd_cnt; rb = rx_log.size();
    send_cmd(1'b0, 12'h000, 4'd15);
    repeat (20) step();
    chk("bp_rd_pulses_held", rd_cnt - rdb, 4);
    chk("bp_valid_held", rdata_valid, 1);
    chk("bp_busy", busy, 1);
    rdata_ready = 1'b1;
    wait_rx(rb + 16, 200);
    repeat (5) step();
    chk("bp_rx_total", rx_log.size() - rb, 16);
    chk("bp_rd_pulses_total", rd_cnt - rdb, 16);
    for (int i = 0; i < 16; i++) begin
      e = {(i == 15), 64'hB000 + 64'(i)};
      chk("bp_rd_data", rx_log[rb + i], e);
    end
    chk("bp_busy_drained", busy, 0);

    // Address wrap across 0xFFF
    wb = wr_log.size();
    send_cmd(1'b1, 12'hFFE, 4'd3);
    for (int i = 0; i < 4; i++) wbeat(64'(i + 1));
    step();
    begin
      logic [11:0] wa [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
      for (int i = 0; i < 4; i++) chk("wrap_wr_addr", wr_log[wb + i], wa[i]);
    end
    rb = rx_log.size();
    send_cmd(1'b0, 12'hFFE, 4'd3);
    wait_rx(rb + 4, 40);
    for (int i = 0; i < 4; i++) begin
      e = {(i == 3), 64'(i + 1)};
      chk("wrap_rd_data", rx_log[rb + i], e);
    end

    // Latency-3 instance: 8-beat read streaming back-to-back
    cmd_valid3 = 1'b1; cmd_write3 = 1'b0; cmd_addr3 = 12'h040; cmd_len3 = 4'd7;
    for (int k = 0; k < 50 && !cmd_ready3; k++) step();
    chk("l3_cmd_ready", cmd_ready3, 1);
    step();
    cmd_valid3 = 1'b0;
    for (int k = 0; k < 60 && rx3_log.size() < 8; k++) step();
    chk("l3_rx_count", rx3_log.size(), 8);
    chk("l3_first_latency", rv_first - rr_first, 4);
    for (int i = 0; i < 8 && i < rx3_log.size(); i++) begin
      e = {(i == 7), 64'hA5A5_0000_0000_0040 + 64'(i)};
      chk("l3_rd_data", rx3_log[i], e);
      chk("l3_rate", rx3_cyc[i] - rv_first, i);
    end
    step(); step();
    chk("l3_write_side_quiet", {wr3_cnt[0], wdata_ready3, ram_write3, ram_wr_address3, ram_data_in3}, 0);
    chk("l3_busy_done", busy3, 0);

    // Reset in the middle of a read burst
    rdata_ready = 1'b0;
    rb = rx_log.size();
    send_cmd(1'b0, 12'h010, 4'd15);
    step(); step(); step();
    chk("mid_rst_strobing", ram_read, 1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_outputs", {cmd_ready, wdata_ready, rdata_valid, rdata_last, busy, ram_write, ram_read,
                            ram_wr_address, ram_rd_address, ram_data_in, rdata}, 0);
    snap = rd_cnt;
    step(); step();
    resetn = 1'b1;
    rdata_ready = 1'b1;
    repeat (6) step();
    chk("mid_rst_no_strobes", rd_cnt - snap, 0);
    chk("mid_rst_valid", rdata_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_no_rx", rx_log.size() - rb, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("rw_exclusive", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
